sobel_frame_server: RTL and testbench
=====================================

SOBEL_FRAME_SERVER -- requirements
Module: sobel_frame_server

Interface
REQ-001 SHALL have parameter KEY_DEFAULT, default 9'h1A2, the working_key value driven to the Sobel core.
REQ-002 SHALL have parameter FRAME_PIX, default 262144, the pixels per frame (512x512, address = {Y[8:0],X[8:0]}).
REQ-003 ap_clk  in  1  single clock; all logic on rising edge.
REQ-004 ap_rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  host frame request; busy  out  1  high outside IDLE; frame_done  out  1  one-cycle pulse at end of DRAIN.
REQ-006 s_valid  in  1; s_data  in  8; s_ready  out  1  pixel load stream.
REQ-007 m_valid  out  1; m_data  out  8; m_last  out  1; m_ready  in  1  result stream.
REQ-008 core_ap_start  out  1; core_ap_done, core_ap_idle, core_ap_ready  in  1 each.
REQ-009 indata_address0  in  18; indata_ce0  in  1; indata_q0  out  8.
REQ-010 outdata_address0  in  18; outdata_ce0, outdata_we0  in  1 each; outdata_d0  in  8.
REQ-011 GX_address0, GY_address0  in  18 each; GX_ce0, GY_ce0  in  1 each; GX_q0, GY_q0  out  32 each.
REQ-012 working_key  out  9  core configuration key.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> RUN -> WAIT -> DRAIN -> IDLE.
REQ-014 IDLE: start=1 -> LOAD, write pointer cleared; start outside IDLE ignored.
REQ-015 LOAD: s_ready=1; each s_valid&s_ready writes s_data to input RAM at pointer, pointer increments; after write at FRAME_PIX-1 -> RUN next cycle.
REQ-016 RUN: core_ap_start=1, held until sampled with core_ap_ready=1, then -> WAIT with core_ap_start=0.
REQ-017 WAIT: core_ap_done=1 -> DRAIN, read pointer cleared; core_ap_done outside RUN/WAIT ignored.
REQ-018 indata port: indata_ce0=1 in cycle N -> indata_q0 = input RAM[indata_address0] in cycle N+1; q0 holds its last value when ce0=0.
REQ-019 GX/GY ports: same 1-cycle latency; address 0..8 return sign-extended GX={-1,0,1,-2,0,2,-1,0,1}, GY={-1,-2,-1,0,0,0,1,2,1}; address >8 returns 0.
REQ-020 outdata port: outdata_ce0&outdata_we0 writes outdata_d0 to output RAM[outdata_address0] in any state; ce0 without we0 has no effect.
REQ-021 DRAIN: output RAM streamed in address order 0..FRAME_PIX-1; m_valid/m_data held stable until m_ready; no bubble when m_ready stays high after first beat; m_last=1 only on FRAME_PIX-1 beat.
REQ-022 Accepted last beat -> frame_done=1 for one cycle -> IDLE.
REQ-023 Simultaneous start and frame_done cycle: start ignored (FSM not in IDLE).
REQ-024 Input RAM address wraps modulo 2^18; no out-of-range error.

Reset
REQ-025 ap_rst=1 SHALL immediately force IDLE, busy=0, frame_done=0, s_ready=0, m_valid=0, m_last=0, core_ap_start=0, indata_q0=0, GX_q0=0, GY_q0=0, pointers=0.
REQ-026 Reset mid-frame SHALL abort without clearing RAM contents; next start reloads from address 0.

Configuration
REQ-027 Macro SOBEL_SRV_KEY_PROG_EN defined: inputs key_wr (1) and key_data (9) added; key register resets to KEY_DEFAULT, written on key_wr only in IDLE, drives working_key.
REQ-028 Macro undefined: no key ports; working_key constant KEY_DEFAULT.

Verification
REQ-029 Load ramp pixel=addr[7:0], start -> core_ap_start high until ap_ready, busy=1, s_ready low after beat FRAME_PIX-1.
REQ-030 indata_ce0=1, address 0x00203 -> indata_q0=8'h03 next cycle; ce0=0 -> q0 held.
REQ-031 GX address 5 -> GX_q0=32'h00000002; GY address 1 -> 32'hFFFFFFFE; GX address 12 -> 0.
REQ-032 Write outdata 8'hA5 at 0x3FFFF, assert core_ap_done, m_ready toggling 1/0 -> last beat m_data=8'hA5, m_last=1, frame_done one pulse, return to IDLE.
REQ-033 ap_rst pulse during DRAIN -> all outputs at reset values same cycle; new start accepted afterwards.
REQ-034 With SOBEL_SRV_KEY_PROG_EN: key_wr=1, key_data=9'h0F0 in IDLE -> working_key=9'h0F0; key_wr during LOAD -> no change.

Source files
------------

// File: rtl/sobel_frame_server.sv
// sobel_frame_server: frame-buffer wrapper around an HLS-style Sobel core.
// A host streams one frame of pixels in. The core is started and its
// indata/GX/GY/outdata memory ports are served. The result frame is then
// streamed back out. Defining SOBEL_SRV_KEY_PROG_EN adds a host-writable key
// register. Without it, working_key is the constant KEY_DEFAULT.
module sobel_frame_server #(
  parameter logic [8:0]  KEY_DEFAULT = 9'h1A2,
  parameter int unsigned FRAME_PIX   = 262144
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        core_ap_start,
  input  logic        core_ap_done,
  input  logic        core_ap_idle,
  input  logic        core_ap_ready,
  input  logic [17:0] indata_address0,
  input  logic        indata_ce0,
  output logic [7:0]  indata_q0,
  input  logic [17:0] outdata_address0,
  input  logic        outdata_ce0,
  input  logic        outdata_we0,
  input  logic [7:0]  outdata_d0,
  input  logic [17:0] GX_address0,
  input  logic        GX_ce0,
  output logic [31:0] GX_q0,
  input  logic [17:0] GY_address0,
  input  logic        GY_ce0,
  output logic [31:0] GY_q0,
`ifdef SOBEL_SRV_KEY_PROG_EN
  input  logic        key_wr,
  input  logic [8:0]  key_data,
`endif
  output logic [8:0]  working_key
);

  localparam logic [17:0] LAST_ADDR = 18'(FRAME_PIX - 1);
  localparam logic [18:0] FRAME_CNT = 19'(FRAME_PIX);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StWait, StDrain} state_e;

  state_e      state_q, state_d;
  logic [17:0] wr_ptr_q;
  logic [18:0] rd_ptr_q;      // beats issued to the output register; one bit wider than the address
  logic        done_seen_q;   // core finished while start was still being handshaken
  logic        leave_wait;
  logic        load_beat;
  logic        unused_idle;

  logic [7:0] in_ram  [0:262143];
  logic [7:0] out_ram [0:262143];

  // The core's idle flag carries no information the server needs.
  assign unused_idle = core_ap_idle;

  assign leave_wait = core_ap_done || done_seen_q;
  // Refill the output register when it is empty or being consumed, until all beats are issued.
  assign load_beat  = (state_q == StDrain) && (rd_ptr_q < FRAME_CNT) && !frame_done &&
                      (!m_valid || m_ready);

  // Kernel coefficient ROMs: 3x3 Sobel, row-major, sign-extended to 32 bits.
  function automatic logic [31:0] gx_coef(input logic [17:0] a);
    case (a)
      18'd0, 18'd6: gx_coef = 32'hFFFF_FFFF;
      18'd2, 18'd8: gx_coef = 32'h0000_0001;
      18'd3:        gx_coef = 32'hFFFF_FFFE;
      18'd5:        gx_coef = 32'h0000_0002;
      default:      gx_coef = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] gy_coef(input logic [17:0] a);
    case (a)
      18'd0, 18'd2: gy_coef = 32'hFFFF_FFFF;
      18'd1:        gy_coef = 32'hFFFF_FFFE;
      18'd6, 18'd8: gy_coef = 32'h0000_0001;
      18'd7:        gy_coef = 32'h0000_0002;
      default:      gy_coef = 32'h0000_0000;
    endcase
  endfunction

  // FSM state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  if (s_valid && (wr_ptr_q == LAST_ADDR)) state_d = StRun;
      StRun:   if (core_ap_ready) state_d = StWait;
      StWait:  if (leave_wait) state_d = StDrain;
      StDrain: if (frame_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    busy          = (state_q != StIdle);
    s_ready       = (state_q == StLoad);
    core_ap_start = (state_q == StRun);
  end

  // Pointers, output stream register and the end-of-frame pulse.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      done_seen_q <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        StIdle: begin
          done_seen_q <= 1'b0;
          if (start) wr_ptr_q <= '0;
        end
        StLoad:  if (s_valid) wr_ptr_q <= wr_ptr_q + 18'd1;
        StRun:   if (core_ap_done) done_seen_q <= 1'b1;
        StWait: begin
          if (leave_wait) begin
            rd_ptr_q    <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            done_seen_q <= 1'b0;
          end
        end
        StDrain: begin
          if (load_beat) begin
            m_data   <= out_ram[rd_ptr_q[17:0]];
            m_last   <= (rd_ptr_q == FRAME_CNT - 19'd1);
            m_valid  <= 1'b1;
            rd_ptr_q <= rd_ptr_q + 19'd1;
          end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (m_last) frame_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Input RAM fill from the pixel stream; the pointer wraps naturally at 2^18.
  always_ff @(posedge ap_clk) begin
    if ((state_q == StLoad) && s_valid) in_ram[wr_ptr_q] <= s_data;
  end

  // Output RAM written by the core in any state.
  always_ff @(posedge ap_clk) begin
    if (outdata_ce0 && outdata_we0) out_ram[outdata_address0] <= outdata_d0;
  end

  // Core read ports: one-cycle latency, data held while ce0 is low.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      indata_q0 <= '0;
      GX_q0     <= '0;
      GY_q0     <= '0;
    end else begin
      if (indata_ce0) indata_q0 <= in_ram[indata_address0];
      if (GX_ce0)     GX_q0     <= gx_coef(GX_address0);
      if (GY_ce0)     GY_q0     <= gy_coef(GY_address0);
    end
  end

`ifdef SOBEL_SRV_KEY_PROG_EN
  logic [8:0] key_q;

  // Host key register, writable only between frames.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)                            key_q <= KEY_DEFAULT;
    else if (key_wr && (state_q == StIdle)) key_q <= key_data;
  end

  assign working_key = key_q;
`else
  assign working_key = KEY_DEFAULT;
`endif

endmodule

// File: tb/tb_sobel_frame_server.sv
// Testbench for sobel_frame_server: a reduced frame size, randomized pixel and
// result data, an expected-beat queue drained by an independent stream monitor.
module tb_sobel_frame_server;

  localparam int unsigned N   = 1024;
  localparam logic [8:0]  KEY = 9'h1A2;

  logic        ap_clk = 1'b0;
  logic        ap_rst, start, busy, frame_done;
  logic        s_valid, s_ready, m_valid, m_last, m_ready;
  logic [7:0]  s_data, m_data, indata_q0, outdata_d0;
  logic        core_ap_start, core_ap_done, core_ap_idle, core_ap_ready;
  logic [17:0] indata_address0, outdata_address0, GX_address0, GY_address0;
  logic        indata_ce0, outdata_ce0, outdata_we0, GX_ce0, GY_ce0;
  logic [31:0] GX_q0, GY_q0;
  logic [8:0]  working_key;
`ifdef SOBEL_SRV_KEY_PROG_EN
  logic        key_wr;
  logic [8:0]  key_data;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] in_model  [N];
  logic [7:0] out_model [N];
  logic [8:0] exp_q [$];  // {last, data} in stream order
  int gx_tab [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int gy_tab [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  sobel_frame_server #(.KEY_DEFAULT(KEY), .FRAME_PIX(N)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .busy(busy), .frame_done(frame_done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .core_ap_start(core_ap_start), .core_ap_done(core_ap_done), .core_ap_idle(core_ap_idle),
    .core_ap_ready(core_ap_ready),
    .indata_address0(indata_address0), .indata_ce0(indata_ce0), .indata_q0(indata_q0),
    .outdata_address0(outdata_address0), .outdata_ce0(outdata_ce0),
    .outdata_we0(outdata_we0), .outdata_d0(outdata_d0),
    .GX_address0(GX_address0), .GX_ce0(GX_ce0), .GX_q0(GX_q0),
    .GY_address0(GY_address0), .GY_ce0(GY_ce0), .GY_q0(GY_q0),
`ifdef SOBEL_SRV_KEY_PROG_EN
    .key_wr(key_wr), .key_data(key_data),
`endif
    .working_key(working_key)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [31:0] coef(input int tab [9], input int a);
    return (a <= 8) ? 32'(tab[a]) : 32'h0;
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_core_ap_start"}, core_ap_start, 0);
    chk({tag, "_indata_q0"}, indata_q0, 0);
    chk({tag, "_GX_q0"}, GX_q0, 0);
    chk({tag, "_GY_q0"}, GY_q0, 0);
  endtask

  // Read-port checks: one-cycle latency, then hold with ce0 low.
  task automatic port_reads(input bit fixed);
    int a, g, y;
    logic [7:0]  e_in;
    logic [31:0] e_gx, e_gy;
    for (int k = 0; k < 8; k++) begin
      a = $urandom_range(N - 1);
      g = $urandom_range(12);
      y = $urandom_range(12);
      if (fixed && k == 0) begin a = 'h203; g = 5; y = 1; end
      if (fixed && k == 1) begin g = 12; y = 7; end
      indata_ce0 = 1; indata_address0 = 18'(a);
      GX_ce0 = 1; GX_address0 = 18'(g);
      GY_ce0 = 1; GY_address0 = 18'(y);
      tick();
      e_in = in_model[a];
      e_gx = coef(gx_tab, g);
      e_gy = coef(gy_tab, y);
      if (fixed && k == 0) begin
        chk("indata_0x203", indata_q0, 8'h03);
        chk("gx_addr5", GX_q0, 32'h0000_0002);
        chk("gy_addr1", GY_q0, 32'hFFFF_FFFE);
      end
      if (fixed && k == 1) chk("gx_addr12", GX_q0, 32'h0);
      chk("indata_q0", indata_q0, e_in);
      chk("GX_q0", GX_q0, e_gx);
      chk("GY_q0", GY_q0, e_gy);
      indata_ce0 = 0; indata_address0 = 18'(a ^ 1);
      GX_ce0 = 0; GX_address0 = 18'(g ^ 2);
      GY_ce0 = 0; GY_address0 = 18'(y ^ 2);
      tick();
      chk("indata_q0_hold", indata_q0, e_in);
      chk("GX_q0_hold", GX_q0, e_gx);
      chk("GY_q0_hold", GY_q0, e_gy);
    end
  endtask

  // One complete frame. mode: 0 toggling m_ready, 1 m_ready held high, 2 random.
  task automatic run_frame(input bit ramp, input int mode, input bit abort);
    int  i;
    bit  injected, found;
    int  vcnt;
    logic [7:0] d;
    int  a;
    start = 1;
    tick();
    start = 0;
    chk("load_busy", busy, 1);
    chk("load_s_ready", s_ready, 1);
    i = 0;
    injected = 0;
    while (i < N) begin
      s_valid = ($urandom_range(3) != 0);
      s_data  = ramp ? 8'(i) : 8'($urandom);
      if (i == N / 2 && !injected) begin
        injected = 1;
        start = 1;
        core_ap_done = 1;
`ifdef SOBEL_SRV_KEY_PROG_EN
        key_wr = 1; key_data = 9'h055;
`endif
      end
      tick();
      start = 0;
      core_ap_done = 0;
`ifdef SOBEL_SRV_KEY_PROG_EN
      if (key_wr) chk("key_locked_in_load", working_key, 9'h0F0);
      key_wr = 0;
`endif
      if (s_valid) begin
        in_model[i] = s_data;
        i++;
      end
    end
    s_valid = 0;
    chk("after_load_s_ready", s_ready, 0);
    chk("run_core_ap_start", core_ap_start, 1);
    chk("run_busy", busy, 1);
    repeat ($urandom_range(4, 1)) begin
      tick();
      chk("start_held", core_ap_start, 1);
    end
    core_ap_ready = 1;
    tick();
    core_ap_ready = 0;
    chk("wait_core_ap_start", core_ap_start, 0);
    chk("wait_busy", busy, 1);
    port_reads(ramp);
    for (int k = 0; k < N; k++) begin
      d = (ramp && k == N - 1) ? 8'hA5 : 8'($urandom);
      outdata_ce0 = 1; outdata_we0 = 1; outdata_address0 = 18'(k); outdata_d0 = d;
      out_model[k] = d;
      tick();
    end
    a = $urandom_range(N - 1);
    outdata_we0 = 0; outdata_address0 = 18'(a); outdata_d0 = ~out_model[a];
    tick();
    outdata_ce0 = 1; outdata_we0 = 1; outdata_address0 = 18'h3FFFF; outdata_d0 = 8'h5A;
    tick();
    outdata_ce0 = 0; outdata_we0 = 0;
    for (int k = 0; k < N; k++) exp_q.push_back({(k == N - 1), out_model[k]});
    m_ready = 1;
    core_ap_done = 1;
    tick();
    core_ap_done = 0;
    if (abort) begin
      repeat (N / 2) tick();
      ap_rst = 1;
      #1;
      reset_checks("abort");
      exp_q.delete();
      tick();
      ap_rst = 0;
      m_ready = 0;
      return;
    end
    found = 0;
    vcnt = 0;
    for (int c = 0; c < 8 * N && !found; c++) begin
      if (frame_done) found = 1;
      else begin
        if (m_valid) vcnt++;
        m_ready = (mode == 0) ? ~m_ready : (mode == 1) ? 1'b1 : 1'($urandom_range(1));
        tick();
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL frame_done_timeout actual=none required=pulse");
    end else begin
      chk("all_beats_seen", exp_q.size(), 0);
      if (mode == 1) chk("no_bubble_valid_cycles", vcnt, N);
      start = 1;  // arrives while frame_done is high: must be ignored
      tick();
      start = 0;
      chk("frame_done_one_cycle", frame_done, 0);
      chk("idle_after_done", busy, 0);
      tick();
      chk("start_ignored_at_done", busy, 0);
    end
    m_ready = 0;
  endtask

  // Stream monitor: pops the expected beat on every accepted transfer, checks stall stability.
  initial begin
    logic       stall;
    logic [8:0] stall_beat, e;
    stall = 0;
    stall_beat = '0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst) stall = 0;
      else begin
        if (stall) begin
          chk("stall_valid_held", m_valid, 1);
          chk("stall_beat_held", {m_last, m_data}, stall_beat);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%h required=none", {m_last, m_data});
          end else begin
            e = exp_q.pop_front();
            chk("beat", {m_last, m_data}, e);
          end
          stall = 0;
        end else if (m_valid) begin
          stall = 1;
          stall_beat = {m_last, m_data};
        end else stall = 0;
      end
    end
  end

  initial begin
    ap_rst = 1; start = 0; s_valid = 0; s_data = 0; m_ready = 0;
    core_ap_done = 0; core_ap_idle = 1; core_ap_ready = 0;
    indata_address0 = 0; indata_ce0 = 0; outdata_address0 = 0; outdata_ce0 = 0;
    outdata_we0 = 0; outdata_d0 = 0; GX_address0 = 0; GX_ce0 = 0; GY_address0 = 0; GY_ce0 = 0;
`ifdef SOBEL_SRV_KEY_PROG_EN
    key_wr = 0; key_data = 0;
`endif
    #23;
    reset_checks("reset");
    chk("reset_working_key", working_key, KEY);
    tick();
    ap_rst = 0;
    tick();
    core_ap_done = 1;  // ignored in idle
    tick();
    core_ap_done = 0;
    chk("idle_busy", busy, 0);
`ifdef SOBEL_SRV_KEY_PROG_EN
    key_wr = 1; key_data = 9'h0F0;
    tick();
    key_wr = 0;
    chk("key_write_idle", working_key, 9'h0F0);
`else
    chk("working_key_const", working_key, KEY);
`endif
    run_frame(1'b1, 0, 1'b0);
    run_frame(1'b0, 1, 1'b0);
    run_frame(1'b0, 1, 1'b1);
    // Input RAM survives the aborting reset.
    for (int k = 0; k < 4; k++) begin
      int a;
      a = $urandom_range(N - 1);
      indata_ce0 = 1; indata_address0 = 18'(a);
      tick();
      indata_ce0 = 0;
      chk("ram_kept_after_reset", indata_q0, in_model[a]);
    end
    run_frame(1'b0, 2, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
